// File: rtl/vram_pkg.sv
//------------------------------------------------------------------------------
// Module   : vram_pkg
// Brief    : Shared raster/tile-map constants and the tile fetch address helper
//            for the tile-map VRAM arbiter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package vram_pkg;

  localparam int CNT_W   = 11;
  localparam int ADDR_W  = 11;
  localparam int DATA_W  = 8;
  localparam int TILE_SH = 4;

  localparam logic [CNT_W-1:0] H_ACTIVE = 11'd800;
  localparam logic [CNT_W-1:0] V_ACTIVE = 11'd600;
  localparam logic [CNT_W-1:0] H_LAST   = 11'd1056;
  localparam logic [CNT_W-1:0] V_LAST   = 11'd628;
  localparam logic [CNT_W-1:0] TILE     = 11'd16;

  localparam logic [ADDR_W-1:0] MAP_COLS = 11'd50;

  // Last in-line fetch slot (hcnt = 16*48) and the next-line column-0 slot.
  localparam logic [CNT_W-1:0] LAST_LINE_SLOT = H_ACTIVE - TILE - TILE;
  localparam logic [CNT_W-1:0] WRAP_SLOT      = H_LAST - TILE;

  // Row-major tile address, wrapped to the VRAM address width.
  function automatic logic [ADDR_W-1:0] fetch_addr(input logic [ADDR_W-1:0] row,
                                                   input logic [ADDR_W-1:0] col);
    return row * MAP_COLS + col;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vram_rr_arb.sv
//------------------------------------------------------------------------------
// Module   : vram_rr_arb
// Brief    : Two-requester round-robin arbiter. A requester whose grant is
//            currently high is masked, and the pointer favours the requester
//            not granted last. Grants are registered; picks are combinational.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module vram_rr_arb (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic req0,
  input  logic req1,
  output logic pick0,
  output logic pick1,
  output logic gnt0,
  output logic gnt1
);

  logic w_elig0;
  logic w_elig1;
  logic r_last1;

  // Eligibility, pointer-based tie break and slot gating.
  always_comb begin
    w_elig0 = req0 & ~gnt0;
    w_elig1 = req1 & ~gnt1;
    pick0   = en & w_elig0 & (~w_elig1 | r_last1);
    pick1   = en & w_elig1 & (~w_elig0 | ~r_last1);
  end

  // Grant registers and last-granted pointer; reset favours requester 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      r_last1 <= 1'b1;
    end else begin
      gnt0 <= pick0;
      gnt1 <= pick1;
      if (pick0) begin
        r_last1 <= 1'b0;
      end else if (pick1) begin
        r_last1 <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/vram_arbiter.sv
//------------------------------------------------------------------------------
// Module   : vram_arbiter
// Brief    : Single-port tile-map VRAM sequencer. Display tile fetches decoded
//            from hcnt/vcnt have absolute priority; other cycles go round-robin
//            to two writers. Fetched tile codes leave through a read pipeline.
//            Optional macro VRAM_WR_BLANK_ONLY_EN restricts writes to vertical
//            blanking (vcnt >= V_ACTIVE).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module vram_arbiter
  import vram_pkg::*;
(
  input  logic              clk25m,
  input  logic              rst_n,
  input  logic [CNT_W-1:0]  hcnt,
  input  logic [CNT_W-1:0]  vcnt,
  input  logic              wr0_req,
  input  logic [ADDR_W-1:0] wr0_addr,
  input  logic [DATA_W-1:0] wr0_data,
  output logic              wr0_gnt,
  input  logic              wr1_req,
  input  logic [ADDR_W-1:0] wr1_addr,
  input  logic [DATA_W-1:0] wr1_data,
  output logic              wr1_gnt,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] tile_data,
  output logic              tile_valid,
  output logic              frame_start
);

  logic [CNT_W-1:0]  w_next_line;
  logic              w_line_slot;
  logic              w_wrap_slot;
  logic              w_fetch_slot;
  logic [ADDR_W-1:0] w_row;
  logic [ADDR_W-1:0] w_col;
  logic              w_wr_ok;
  logic              w_pick0;
  logic              w_pick1;
  logic              r_rd_p1;
  logic              r_rd_p2;

  // Fetch slot decode and tile coordinates from the sampled raster counters.
  always_comb begin
    w_next_line  = (vcnt == V_LAST) ? '0 : vcnt + CNT_W'(1);
    w_line_slot  = (hcnt[TILE_SH-1:0] == '0) && (hcnt <= LAST_LINE_SLOT) &&
                   (vcnt < V_ACTIVE);
    w_wrap_slot  = (hcnt == WRAP_SLOT) && (w_next_line < V_ACTIVE);
    w_fetch_slot = w_line_slot | w_wrap_slot;
    w_row        = '0;
    w_col        = '0;
    if (w_wrap_slot) begin
      w_row = ADDR_W'(w_next_line >> TILE_SH);
    end else begin
      w_row = ADDR_W'(vcnt >> TILE_SH);
      w_col = ADDR_W'(hcnt >> TILE_SH) + ADDR_W'(1);
    end
  end

`ifdef VRAM_WR_BLANK_ONLY_EN
  // Writers only touch the map while the display is in vertical blanking.
  assign w_wr_ok = (vcnt >= V_ACTIVE);
`else
  assign w_wr_ok = 1'b1;
`endif

  vram_rr_arb u_rr_arb (
    .clk   (clk25m),
    .rst_n (rst_n),
    .en    (~w_fetch_slot & w_wr_ok),
    .req0  (wr0_req),
    .req1  (wr1_req),
    .pick0 (w_pick0),
    .pick1 (w_pick1),
    .gnt0  (wr0_gnt),
    .gnt1  (wr1_gnt)
  );

  // Registered RAM port: fetch first, then the arbitrated writer, else idle
  // with address and write data held.
  always_ff @(posedge clk25m or negedge rst_n) begin
    if (!rst_n) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (w_fetch_slot) begin
      mem_en   <= 1'b1;
      mem_we   <= 1'b0;
      mem_addr <= fetch_addr(w_row, w_col);
    end else if (w_pick0) begin
      mem_en    <= 1'b1;
      mem_we    <= 1'b1;
      mem_addr  <= wr0_addr;
      mem_wdata <= wr0_data;
    end else if (w_pick1) begin
      mem_en    <= 1'b1;
      mem_we    <= 1'b1;
      mem_addr  <= wr1_addr;
      mem_wdata <= wr1_data;
    end else begin
      mem_en <= 1'b0;
      mem_we <= 1'b0;
    end
  end

  // Read pipeline: read issued, RAM data valid, tile register loaded.
  always_ff @(posedge clk25m or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_p1     <= 1'b0;
      r_rd_p2     <= 1'b0;
      tile_valid  <= 1'b0;
      tile_data   <= '0;
      frame_start <= 1'b0;
    end else begin
      r_rd_p1     <= w_fetch_slot;
      r_rd_p2     <= r_rd_p1;
      tile_valid  <= r_rd_p2;
      frame_start <= (hcnt == '0) && (vcnt == '0);
      if (r_rd_p2) begin
        tile_data <= mem_rdata;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vram_arbiter.sv
//------------------------------------------------------------------------------
// Module   : tb_vram_arbiter
// Brief    : Scoreboard bench for vram_arbiter. Directed raster/request vectors
//            push expected RAM accesses, tiles and frame pulses with their
//            expected cycle; a negedge monitor pops and compares them.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_vram_arbiter;

  logic        clk;
  logic        rst_n;
  logic [10:0] hcnt;
  logic [10:0] vcnt;
  logic        wr0_req;
  logic [10:0] wr0_addr;
  logic [7:0]  wr0_data;
  logic        wr0_gnt;
  logic        wr1_req;
  logic [10:0] wr1_addr;
  logic [7:0]  wr1_data;
  logic        wr1_gnt;
  logic        mem_en;
  logic        mem_we;
  logic [10:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic [7:0]  tile_data;
  logic        tile_valid;
  logic        frame_start;

  typedef struct {
    int          stamp;
    logic [10:0] addr;
    logic [7:0]  data;
    int          who;
  } exp_t;

  exp_t fq[$];
  exp_t wq[$];
  exp_t tq[$];
  int   sq[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int dstamp   = 0;

  vram_arbiter dut (
    .clk25m      (clk),
    .rst_n       (rst_n),
    .hcnt        (hcnt),
    .vcnt        (vcnt),
    .wr0_req     (wr0_req),
    .wr0_addr    (wr0_addr),
    .wr0_data    (wr0_data),
    .wr0_gnt     (wr0_gnt),
    .wr1_req     (wr1_req),
    .wr1_addr    (wr1_addr),
    .wr1_data    (wr1_data),
    .wr1_gnt     (wr1_gnt),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .tile_data   (tile_data),
    .tile_valid  (tile_valid),
    .frame_start (frame_start)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: read data is a known function of the address, one cycle later.
  initial mem_rdata = 8'h00;
  always @(posedge clk) begin
    if (mem_en && !mem_we) mem_rdata <= mem_addr[7:0] ^ 8'h5A;
  end

  task automatic chk(input bit ok, input string nm, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic drive(input int h, input int v, input bit r0, input bit r1);
    @(negedge clk);
    #2;
    hcnt    = h[10:0];
    vcnt    = v[10:0];
    wr0_req = r0;
    wr1_req = r1;
    dstamp  = cyc + 1;
  endtask

  task automatic exp_fetch(input int a);
    exp_t e;
    e.stamp = dstamp; e.addr = a[10:0]; e.data = 8'h00; e.who = 0;
    fq.push_back(e);
    e.stamp = dstamp + 2; e.data = a[7:0] ^ 8'h5A;
    tq.push_back(e);
  endtask

  task automatic exp_wr(input int who);
    exp_t e;
    e.stamp = dstamp;
    e.who   = who;
    e.addr  = (who == 0) ? wr0_addr : wr1_addr;
    e.data  = (who == 0) ? wr0_data : wr1_data;
    wq.push_back(e);
  endtask

  // Monitor: every RAM access, tile pulse and frame pulse must match the
  // head of its queue, including the cycle it appears on.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (mem_en && !mem_we) begin
        if (fq.size() == 0) chk(1'b0, "fetch_unexpected", mem_addr, 0);
        else begin
          e = fq.pop_front();
          chk(mem_addr == e.addr, "fetch_addr", mem_addr, e.addr);
          chk(cyc == e.stamp, "fetch_cycle", cyc, e.stamp);
        end
      end
      if (mem_en && mem_we) begin
        if (wq.size() == 0) chk(1'b0, "write_unexpected", mem_addr, 0);
        else begin
          e = wq.pop_front();
          chk({wr1_gnt, wr0_gnt} == ((e.who == 0) ? 2'b01 : 2'b10), "write_gnt",
              {wr1_gnt, wr0_gnt}, (e.who == 0) ? 1 : 2);
          chk({mem_addr, mem_wdata} == {e.addr, e.data}, "write_addr_data",
              {mem_addr, mem_wdata}, {e.addr, e.data});
          chk(cyc == e.stamp, "write_cycle", cyc, e.stamp);
        end
      end else if (wr0_gnt || wr1_gnt) begin
        chk(1'b0, "gnt_without_write", {wr1_gnt, wr0_gnt}, 0);
      end
      if (tile_valid) begin
        if (tq.size() == 0) chk(1'b0, "tile_unexpected", tile_data, 0);
        else begin
          e = tq.pop_front();
          chk(tile_data == e.data, "tile_data", tile_data, e.data);
          chk(cyc == e.stamp, "tile_cycle", cyc, e.stamp);
        end
      end
      if (frame_start) begin
        if (sq.size() == 0) chk(1'b0, "frame_unexpected", 1, 0);
        else begin
          int s;
          s = sq.pop_front();
          chk(cyc == s, "frame_cycle", cyc, s);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int seq [11];
    rst_n    = 1'b0;
    hcnt     = 11'd200;
    vcnt     = 11'd610;
    wr0_req  = 1'b0;
    wr1_req  = 1'b0;
    wr0_addr = 11'h123;
    wr0_data = 8'hA0;
    wr1_addr = 11'h456;
    wr1_data = 8'hB1;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk({mem_en, mem_we, mem_addr, mem_wdata, tile_data, tile_valid, frame_start,
         wr0_gnt, wr1_gnt} == '0, "reset_state",
        {mem_en, mem_we, mem_addr, mem_wdata, tile_data, tile_valid, frame_start,
         wr0_gnt, wr1_gnt}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset asserted mid-grant at hcnt=200.
    drive(200, 610, 1, 0);
    @(posedge clk);
    #1;
    chk(wr0_gnt && mem_we && mem_addr == 11'h123, "pre_reset_gnt",
        {wr0_gnt, mem_we, mem_addr}, {1'b1, 1'b1, 11'h123});
    #4;
    rst_n = 1'b0;
    #1;
    chk({mem_en, mem_we, mem_addr, mem_wdata, tile_data, tile_valid, frame_start,
         wr0_gnt, wr1_gnt} == '0, "mid_reset_clear",
        {mem_en, mem_we, mem_addr, mem_wdata, tile_data, tile_valid, frame_start,
         wr0_gnt, wr1_gnt}, 0);
    drive(200, 610, 0, 0);
    drive(200, 610, 0, 0);
    rst_n = 1'b1;

    // First contention after reset favours wr0, then alternates.
    drive(201, 610, 1, 1); exp_wr(0);
    drive(202, 610, 1, 1); exp_wr(1);
    drive(203, 610, 1, 1); exp_wr(0);
    drive(204, 610, 0, 0);
    @(posedge clk);
    #1;
    chk(!mem_en && !mem_we && mem_addr == 11'h123 && mem_wdata == 8'hA0, "idle_hold",
        {mem_en, mem_we, mem_addr, mem_wdata}, {2'b00, 11'h123, 8'hA0});

`ifndef VRAM_WR_BLANK_ONLY_EN
    // Both writers held across the hcnt=16 fetch slot (-1 marks the fetch).
    seq = '{1, 0, 1, 0, 1, 0, -1, 1, 0, 1, 0};
    for (int i = 0; i < 11; i++) begin
      drive(10 + i, 37, 1, 1);
      if (seq[i] < 0) exp_fetch(102);
      else exp_wr(seq[i]);
    end
    drive(21, 37, 0, 0);

    // Request first seen with the hcnt=16 slot: fetch wins, wr0 follows.
    drive(15, 37, 0, 0);
    drive(16, 37, 1, 0); exp_fetch(102);
    drive(17, 37, 1, 0); exp_wr(0);
    drive(18, 37, 0, 0);

    // Active-region write is allowed.
    drive(5, 100, 0, 1); exp_wr(1);
    drive(6, 100, 0, 0);
`else
    // Active-region request stalls until vertical blanking.
    drive(5, 100, 0, 1);
    drive(6, 100, 0, 1);
    drive(7, 599, 0, 1);
    drive(5, 600, 0, 1); exp_wr(1);
    drive(6, 600, 0, 0);
`endif

    // Full line at vcnt=37 (row 2).
    for (int h = 0; h <= 1056; h++) begin
      drive(h, 37, 0, 0);
      if ((h % 16) == 0 && h <= 768) exp_fetch(101 + h / 16);
      if (h == 1040) exp_fetch(100);
    end

    // Next-line and frame boundary slots.
    drive(1040, 628, 0, 0); exp_fetch(0);
    drive(1040, 599, 0, 0);
    drive(1040, 627, 0, 0);
    drive(0, 599, 0, 0);    exp_fetch(1851);
    drive(0, 600, 0, 0);
    drive(0, 0, 0, 0);      exp_fetch(1); sq.push_back(dstamp);
    drive(1, 0, 0, 0);

    repeat (5) drive(5, 610, 0, 0);
    chk(fq.size() == 0, "fetch_queue_drained", fq.size(), 0);
    chk(wq.size() == 0, "write_queue_drained", wq.size(), 0);
    chk(tq.size() == 0, "tile_queue_drained", tq.size(), 0);
    chk(sq.size() == 0, "frame_queue_drained", sq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
